// File: rtl/mux_arb_n_if.sv
// Handshake bundle for mux_arb_n: N producer channels in, one registered consumer channel out.
// The arbiter sits on the slave modport; producers and the consumer drive the master side.
interface mux_arb_n_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4
) ();
    localparam int unsigned SELW = $clog2(N);

    logic                 mode;
    logic [N-1:0]         in_valid;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_sel;
    logic                 out_ready;

    modport master (
        output mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux_arb_n.sv
// N-way arbitrating mux with a one-entry registered output stage.
// Fixed-priority (lowest index) or round-robin from a pointer that follows the last grant.
module mux_arb_n #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4
) (
    input  logic            clk,
    input  logic            reset,
    mux_arb_n_if.slave      bus
);
    localparam int unsigned SELW = $clog2(N);

    logic [SELW-1:0]  r_ptr;
    logic [SELW-1:0]  r_sel;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    logic             w_load;
    logic             w_fire;
    logic [SELW-1:0]  w_start;
    logic             w_hi_found;
    logic             w_lo_found;
    logic [SELW-1:0]  w_hi_idx;
    logic [SELW-1:0]  w_lo_idx;
    logic [SELW-1:0]  w_gidx;
    logic [SELW-1:0]  w_ptr_next;
    logic [N-1:0]     w_grant;
    logic [WIDTH-1:0] w_gdata;

    assign w_load  = ~r_valid | bus.out_ready;
    assign w_start = bus.mode ? r_ptr : '0;

    // Two scans: lowest requester at or above the start index, else lowest overall (the wrap).
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = SELW'(i);
                if (SELW'(i) >= w_start) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = SELW'(i);
                end
            end
        end
    end

    assign w_gidx     = w_hi_found ? w_hi_idx : w_lo_idx;
    assign w_fire     = ~reset & w_load & w_lo_found;
    assign w_ptr_next = (w_gidx == SELW'(N - 1)) ? '0 : w_gidx + 1'b1;

    always_comb begin
        w_grant = '0;
        if (w_fire) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    always_comb begin
        w_gdata = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (w_grant[i]) begin
                w_gdata = w_gdata | bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else if (w_fire) begin
            r_valid <= 1'b1;
            r_data  <= w_gdata;
            r_sel   <= w_gidx;
            r_ptr   <= w_ptr_next;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_grant;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.out_sel   = r_sel;
endmodule

// File: doc/mux_arb_n.md
# mux_arb_n

Parametrised N-channel, WIDTH-bit registered arbitrating multiplexer with valid/ready handshakes on every input and on the output. It generalises the datapath's 2- and 4-way selectors. The select is no longer a raw input: the block chooses among requesting channels with fixed-priority or round-robin arbitration. It then holds the winning word in a one-entry output register until the downstream consumer accepts it. It sits between multiple producers, such as register-file write sources or memory-return paths, and a single consumer.

## Interface
- WIDTH, 32, data width per channel (≥1)
- N, 4, number of input channels (≥2)
- SELW, $clog2(N), width of channel index (derived, not overridden)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin
- in_valid  in  N  per-channel request; bit i belongs to channel i
- in_data  in  N*WIDTH  flattened channel data; channel i at [i*WIDTH +: WIDTH]
- in_ready  out  N  one-hot-or-zero grant; channel i's word is taken when in_valid[i] & in_ready[i]
- out_valid  out  1  output register holds a word
- out_data  out  WIDTH  registered winning word
- out_sel  out  SELW  index of the channel that supplied out_data
- out_ready  in  1  consumer accepts; transfer when out_valid & out_ready

## Operation
- load = ~out_valid | out_ready, which is combinational. The output register can take a new word this cycle.
- in_ready is combinational from in_valid, mode, the priority pointer and load:
  - in_ready = 0 when load = 0 or in_valid = 0.
  - Otherwise exactly one bit is set, for the arbitration winner.
- Fixed priority (mode=0): the winner is the lowest index i with in_valid[i]=1. The pointer is ignored, but it still updates as below.
- Round-robin (mode=1): the winner is the first i with in_valid[i]=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N).
- On an accepted grant to channel g:
  - out_data ← in_data[g], out_sel ← g, out_valid ← 1.
  - ptr ← g+1, wrapping N-1 → 0.
- Output drained with no new grant (out_valid & out_ready & no in_valid): out_valid ← 0. out_data and out_sel hold their last values.
- Simultaneous drain and grant: a new word is loaded in the same cycle, so back-to-back throughput is 1 word/cycle.
- Stall (out_valid & ~out_ready):
  - in_ready = 0; the register, ptr, out_data and out_sel hold.
  - in_valid may change freely; arbitration is re-evaluated every cycle, so there is no grant lock.
- mode may change on any cycle. It takes effect on that cycle's arbitration. ptr is unaffected.
- Non-power-of-2 N: ptr and out_sel never take values ≥ N.

## Timing
- Reset (reset=1 at a rising edge):
  - out_valid=0, out_data=0, out_sel=0, ptr=0.
  - in_ready=0 during the reset cycle; reset overrides any concurrent handshake.
- Reset mid-operation drops any held word; it is not delivered.
- Latency: input handshake in cycle t → out_valid=1 with that word from cycle t+1.
- Output handshake and input handshake in the same cycle do not interact beyond load; there are no combinational paths from in_data to out_data.
- Combinational paths permitted: out_ready → in_ready, and in_valid/mode → in_ready. No path from out_ready to out_valid/out_data.
- Round-robin fairness: with all N channels continuously valid and out_ready=1, each channel is granted exactly once per N consecutive cycles.

## Test plan
- Reset: hold in_valid=4'b1111 and out_ready=1, assert reset for 2 cycles → in_ready=0, out_valid=0, out_data=0, out_sel=0 throughout. After release, the first grant in mode=1 goes to channel 0.
- Fixed priority, N=4, WIDTH=32, mode=0: in_valid=4'b1010 with data ch1=0x11111111 and ch3=0x33333333, out_ready=1 →
  - ch1 is granted every cycle and out_sel=1, out_data=0x11111111 from the next cycle on.
  - Drop ch1 → ch3 is granted next and out_sel=3.
- Round-robin rotation, mode=1: in_valid=4'b1111 constant, out_ready=1 → out_sel sequence 0,1,2,3,0,1,… The sequence is one word per cycle with no bubbles. With in_valid=4'b1001 it is 0,3,0,3.
- Backpressure: out_valid=1 with word 0xDEADBEEF from ch2, out_ready=0 for 3 cycles with in_valid=4'b1111 →
  - in_ready=0, and out_data and out_sel stay stable for all 3 cycles.
  - When out_ready=1, the next winner is ch3 (mode=1) and loads the same cycle.
- Drain to empty: single word from ch0, then in_valid=0 and out_ready=1 → out_valid falls after one cycle. out_data holds its value. A new ch2 request then appears on out_data one cycle after its grant.
- Reset mid-stall plus wrap: out_valid=1 held with ptr=3, then assert reset → out_valid=0 and ptr=0. Also run N=3 round-robin with all valid → out_sel sequence 0,1,2,0, never 3.
